// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: request/result handshake bundle for the 20-bit ALU controller.
//   master: drives req_valid, opcode, a, b, res_ready; observes the rest.
//   slave : drives req_ready, res_valid, result, zero, sign, carry, err.
interface alu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  opcode;
    logic [19:0] a;
    logic [19:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] result;
    logic        zero;
    logic        sign;
    logic        carry;
    logic        err;
    modport master (
        output req_valid, opcode, a, b, res_ready,
        input  req_ready, res_valid, result, zero, sign, carry, err
    );
    modport slave (
        input  req_valid, opcode, a, b, res_ready,
        output req_ready, res_valid, result, zero, sign, carry, err
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing controller for a 20-bit ALU (logic, arithmetic, compare, shift/rotate).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : alu_ctrl_if.slave -- request handshake in, result + zero/sign/carry/err out
// Build option: define ALU_CTRL_BARREL_EN for single-cycle barrel shifts; otherwise
// shifts/rotates advance one bit per EXEC cycle.
module alu_ctrl (
    input  logic       clk,
    input  logic       rst,
    alu_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam logic [4:0] OP_NOT = 5'h00, OP_AND = 5'h01, OP_OR = 5'h02, OP_XOR = 5'h03,
                           OP_SHR = 5'h04, OP_SHL = 5'h05, OP_ROTR = 5'h06, OP_ROTL = 5'h07,
                           OP_SWAP = 5'h08, OP_INC = 5'h09, OP_DEC = 5'h0A, OP_ADD = 5'h0B,
                           OP_ADDC = 5'h0C, OP_SUB = 5'h0D, OP_SUBC = 5'h0E, OP_EQ = 5'h0F,
                           OP_GT = 5'h10;
    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d, n_q, n_d, cnt_in, n_in;
    logic [19:0] a_q, a_d, b_q, b_d, result_q, result_d, sh_res, alu_res;
    logic        prime_q, prime_d, zero_q, zero_d, sign_q, sign_d, carry_q, carry_d, err_q, err_d;
    logic        accept, exec_done, carry_upd;
    logic [20:0] sum;
`ifdef ALU_CTRL_BARREL_EN
    logic [39:0] rot_r, rot_l;
`else
    logic [19:0] sh_q, sh_d, sh_step;
    logic        is_shift;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prime_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
`ifndef ALU_CTRL_BARREL_EN
            sh_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            n_q      <= n_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prime_q  <= prime_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
`ifndef ALU_CTRL_BARREL_EN
            sh_q     <= sh_d;
`endif
        end
    end
    // Effective count: rotates wrap mod 20, logical shifts saturate at 20 (all bits gone).
    assign cnt_in = bus.b[4:0];
    always_comb begin
        n_in = 5'd0;
        if (bus.opcode == OP_ROTR || bus.opcode == OP_ROTL)
            n_in = (cnt_in >= 5'd20) ? cnt_in - 5'd20 : cnt_in;
        else if (bus.opcode == OP_SHR || bus.opcode == OP_SHL)
            n_in = (cnt_in >= 5'd20) ? 5'd20 : cnt_in;
    end
`ifdef ALU_CTRL_BARREL_EN
    assign rot_r = {a_q, a_q} >> n_q;
    assign rot_l = {a_q, a_q} << n_q;
    always_comb begin
        sh_res = rot_l[39:20];
        case (op_q)
            OP_SHR:  sh_res = a_q >> n_q;
            OP_SHL:  sh_res = a_q << n_q;
            OP_ROTR: sh_res = rot_r[19:0];
            default: sh_res = rot_l[39:20];
        endcase
    end
    assign exec_done = !prime_q;
`else
    assign is_shift = (op_q[4:2] == 3'b001);
    assign sh_res   = sh_q;
    always_comb begin
        sh_step = {sh_q[18:0], sh_q[19]};
        case (op_q)
            OP_SHR:  sh_step = {1'b0, sh_q[19:1]};
            OP_SHL:  sh_step = {sh_q[18:0], 1'b0};
            OP_ROTR: sh_step = {sh_q[0], sh_q[19:1]};
            default: sh_step = {sh_q[18:0], sh_q[19]};
        endcase
    end
    assign exec_done = !prime_q && !(is_shift && n_q != 5'd0);
`endif
    // 21-bit arithmetic: bit 20 is carry-out for additions and borrow for subtractions.
    always_comb begin
        sum = 21'd0;
        case (op_q)
            OP_INC:  sum = {1'b0, a_q} + 21'd1;
            OP_DEC:  sum = {1'b0, a_q} - 21'd1;
            OP_ADD:  sum = {1'b0, a_q} + {1'b0, b_q};
            OP_ADDC: sum = {1'b0, a_q} + {1'b0, b_q} + {20'd0, carry_q};
            OP_SUB:  sum = {1'b0, a_q} - {1'b0, b_q};
            OP_SUBC: sum = {1'b0, a_q} - {1'b0, b_q} - {20'd0, carry_q};
            default: sum = 21'd0;
        endcase
    end
    assign carry_upd = (op_q >= OP_INC) && (op_q <= OP_SUBC);
    always_comb begin
        alu_res = 20'd0;
        case (op_q)
            OP_NOT:  alu_res = ~a_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SHR, OP_SHL, OP_ROTR, OP_ROTL: alu_res = sh_res;
            OP_SWAP: alu_res = {a_q[9:0], a_q[19:10]};
            OP_INC, OP_DEC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: alu_res = sum[19:0];
            OP_EQ:   alu_res = {19'd0, a_q == b_q};
            OP_GT:   alu_res = {19'd0, a_q > b_q};
            default: alu_res = 20'd0;
        endcase
    end
    assign accept = bus.req_valid && state_q == IDLE;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = exec_done ? DONE : EXEC;
            DONE:    state_d = bus.res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // The first EXEC cycle only lets the latched operands settle, giving every op a
    // two-edge minimum from accept to res_valid.
    always_comb begin
        op_d     = op_q;
        n_d      = n_q;
        a_d      = a_q;
        b_d      = b_q;
        prime_d  = prime_q;
        result_d = result_q;
        zero_d   = zero_q;
        sign_d   = sign_q;
        carry_d  = carry_q;
        err_d    = err_q;
`ifndef ALU_CTRL_BARREL_EN
        sh_d     = sh_q;
`endif
        if (accept) begin
            op_d    = bus.opcode;
            a_d     = bus.a;
            b_d     = bus.b;
            n_d     = n_in;
            prime_d = 1'b1;
`ifndef ALU_CTRL_BARREL_EN
            sh_d    = bus.a;
`endif
        end else if (state_q == EXEC) begin
            prime_d = 1'b0;
            if (exec_done) begin
                result_d = alu_res;
                zero_d   = (alu_res == 20'd0);
                sign_d   = alu_res[19];
                err_d    = (op_q > OP_GT);
                carry_d  = carry_upd ? sum[20] : carry_q;
            end
`ifndef ALU_CTRL_BARREL_EN
            else if (!prime_q) begin
                sh_d = sh_step;
                n_d  = n_q - 5'd1;
            end
`endif
        end
    end
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.res_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.zero      = zero_q;
        bus.sign      = sign_q;
        bus.carry     = carry_q;
        bus.err       = err_q;
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: table-driven, hand-sequenced and randomized checks of alu_ctrl against a behavioural model.
module tb_alu_ctrl;
`ifdef ALU_CTRL_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    alu_ctrl_if bus();
    alu_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit mc     = 1'b0;

    typedef struct {
        logic [4:0]  op;
        logic [19:0] a;
        logic [19:0] b;
        logic [19:0] r;
        bit          z;
        bit          s;
        bit          c;
        bit          e;
        int          n;
    } vec_t;
    vec_t tbl[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Reference model computed from the operation definitions with plain integer arithmetic.
    function automatic void model(input logic [4:0] op, input logic [19:0] a, input logic [19:0] b,
                                  input bit ci, output logic [19:0] r, output bit co,
                                  output bit e, output int n);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint s;
        int cnt = int'(b[4:0]);
        r = 20'd0; co = ci; e = 1'b0; n = 0; s = 0;
        case (op)
            5'h00: r = ~a;
            5'h01: r = a & b;
            5'h02: r = a | b;
            5'h03: r = a ^ b;
            5'h04: begin n = (cnt > 20) ? 20 : cnt; r = (cnt >= 20) ? 20'd0 : a >> cnt; end
            5'h05: begin n = (cnt > 20) ? 20 : cnt; r = (cnt >= 20) ? 20'd0 : a << cnt; end
            5'h06: begin n = cnt % 20; r = (a >> n) | (a << (20 - n)); end
            5'h07: begin n = cnt % 20; r = (a << n) | (a >> (20 - n)); end
            5'h08: r = {a[9:0], a[19:10]};
            5'h09: begin s = ua + 1;           r = 20'(s); co = (s >= 64'd1048576); end
            5'h0A: begin s = ua - 1;           r = 20'(s); co = (s < 0); end
            5'h0B: begin s = ua + ub;          r = 20'(s); co = (s >= 64'd1048576); end
            5'h0C: begin s = ua + ub + ci;     r = 20'(s); co = (s >= 64'd1048576); end
            5'h0D: begin s = ua - ub;          r = 20'(s); co = (s < 0); end
            5'h0E: begin s = ua - ub - ci;     r = 20'(s); co = (s < 0); end
            5'h0F: r = (a == b) ? 20'd1 : 20'd0;
            5'h10: r = (a > b) ? 20'd1 : 20'd0;
            default: e = 1'b1;
        endcase
    endfunction

    // Present a request, return the number of edges from the accept edge to res_valid.
    task automatic issue(input logic [4:0] op, input logic [19:0] a, input logic [19:0] b, output int lat);
        bus.opcode = op; bus.a = a; bus.b = b; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.opcode = 5'($urandom); bus.a = 20'($urandom); bus.b = 20'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.res_valid && lat < 60);
    endtask

    task automatic release_res();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [19:0] er;
        bit ec, ee;
        int en;
        bus.req_valid = 1'b0; bus.res_ready = 1'b0;
        bus.opcode = '0; bus.a = '0; bus.b = '0;
        tbl[0]  = '{5'h0B, 20'hFFFFF, 20'h00001, 20'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{5'h0C, 20'h00001, 20'h00001, 20'h00003, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{5'h0D, 20'h00005, 20'h00007, 20'hFFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[3]  = '{5'h06, 20'h00001, 20'h00001, 20'h80000, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[4]  = '{5'h05, 20'h00001, 20'd25,    20'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 20};
        tbl[5]  = '{5'h07, 20'h00001, 20'd21,    20'h00002, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[6]  = '{5'h0E, 20'h00010, 20'h00003, 20'h0000C, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{5'h10, 20'h00005, 20'h00003, 20'h00001, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{5'h08, 20'h003FF, 20'h00000, 20'hFFC00, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[9]  = '{5'h0A, 20'h00000, 20'h00000, 20'hFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[10] = '{5'h09, 20'hFFFFF, 20'h00000, 20'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[11] = '{5'h01, 20'hF0F0F, 20'h0FF00, 20'h00F00, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[12] = '{5'h1F, 20'h00123, 20'h00456, 20'h00000, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[13] = '{5'h00, 20'h0F0F0, 20'h00000, 20'hF0F0F, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[14] = '{5'h03, 20'hFFFFF, 20'h0F0F0, 20'hF0F0F, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[15] = '{5'h04, 20'h80000, 20'd19,    20'h00001, 1'b0, 1'b0, 1'b1, 1'b0, 19};
        tbl[16] = '{5'h07, 20'h80001, 20'd0,     20'h80001, 1'b0, 1'b1, 1'b1, 1'b0, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);
        check("rst_sign",      32'(bus.sign),      32'd0);
        check("rst_carry",     32'(bus.carry),     32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, lat);
            check($sformatf("tbl%0d_result", i), 32'(bus.result), 32'(tbl[i].r));
            check($sformatf("tbl%0d_zero", i),   32'(bus.zero),   32'(tbl[i].z));
            check($sformatf("tbl%0d_sign", i),   32'(bus.sign),   32'(tbl[i].s));
            check($sformatf("tbl%0d_carry", i),  32'(bus.carry),  32'(tbl[i].c));
            check($sformatf("tbl%0d_err", i),    32'(bus.err),    32'(tbl[i].e));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(BARREL ? 2 : 2 + tbl[i].n));
            release_res();
        end

        // Backpressure: result and handshake state must hold while res_ready stays low.
        issue(5'h0F, 20'h12345, 20'h12345, lat);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_result", i),    32'(bus.result),    32'd1);
            check($sformatf("bp%0d_res_valid", i), 32'(bus.res_valid), 32'd1);
            check($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        release_res();
        check("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("bp_idle_res_valid", 32'(bus.res_valid), 32'd0);

        // Asynchronous reset in the middle of a long SHR must wipe everything, carry included.
        bus.opcode = 5'h04; bus.a = 20'hABCDE; bus.b = 20'd15; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_result",    32'(bus.result),    32'd0);
        check("mid_rst_zero",      32'(bus.zero),      32'd0);
        check("mid_rst_sign",      32'(bus.sign),      32'd0);
        check("mid_rst_carry",     32'(bus.carry),     32'd0);
        check("mid_rst_err",       32'(bus.err),       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mc = 1'b0;
        @(posedge clk); #1;
        issue(5'h01, 20'hF0F0F, 20'h0FF00, lat);
        check("post_rst_and_result", 32'(bus.result), 32'h00F00);
        check("post_rst_and_carry",  32'(bus.carry),  32'd0);
        release_res();

        for (int i = 0; i < 300; i++) begin
            logic [4:0]  op = 5'($urandom_range(0, 20));
            logic [19:0] a  = 20'($urandom);
            logic [19:0] b  = 20'($urandom);
            if (i % 4 == 0) b = a;
            model(op, a, b, mc, er, ec, ee, en);
            mc = ec;
            issue(op, a, b, lat);
            check($sformatf("rnd%0d_op%0h_result", i, op), 32'(bus.result), 32'(er));
            check($sformatf("rnd%0d_op%0h_zero", i, op),   32'(bus.zero),   32'(er == 20'd0));
            check($sformatf("rnd%0d_op%0h_sign", i, op),   32'(bus.sign),   32'(er[19]));
            check($sformatf("rnd%0d_op%0h_carry", i, op),  32'(bus.carry),  32'(ec));
            check($sformatf("rnd%0d_op%0h_err", i, op),    32'(bus.err),    32'(ee));
            check($sformatf("rnd%0d_op%0h_latency", i, op), 32'(lat), 32'(BARREL ? 2 : 2 + en));
            release_res();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing controller for the 20-bit ALU datapath. Accepts one operation request at a time over a valid/ready handshake and registers the operands. Executes logic, arithmetic, comparison and shift/rotate ops; shifts are iterative (one bit per cycle) unless the barrel option is compiled in. Returns the result plus zero, sign, carry and error flags over a second valid/ready handshake, and holds the carry flag between operations so that ADDC/SUBC can chain.

## Interface
- No parameters; datapath width fixed at 20 bits.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- opcode  in  5  operation select, map below.
- a  in  20  operand A.
- b  in  20  operand B; b[4:0] is the shift count for shift/rotate ops.
- res_valid  out  1  result and flags valid; high only in DONE.
- res_ready  in  1  consumer accepts result.
- result  out  20  registered result.
- zero  out  1  result == 0.
- sign  out  1  result[19].
- carry  out  1  persistent carry/borrow flag.
- err  out  1  reserved opcode was executed.

## Operation
- Opcode map:
  - 0x00 NOT a
  - 0x01 AND
  - 0x02 OR
  - 0x03 XOR
  - 0x04 SHR (logical)
  - 0x05 SHL
  - 0x06 ROTR
  - 0x07 ROTL
  - 0x08 SWAP ({a[9:0], a[19:10]})
  - 0x09 INC a
  - 0x0A DEC a
  - 0x0B ADD
  - 0x0C ADDC (a+b+carry)
  - 0x0D SUB (a-b)
  - 0x0E SUBC (a-b-carry)
  - 0x0F EQ ({19'b0, a==b})
  - 0x10 GT ({19'b0, a>b unsigned})
  - 0x11–0x1F reserved: result 0, err=1.
- States: IDLE, EXEC, DONE.
  - IDLE: req_ready=1. On req_valid, latch opcode, a, b and effective count n, then go to EXEC.
  - EXEC: non-shift ops compute in one cycle. Shift ops with n≠0 move one bit per cycle, decrement n, and stay in EXEC. When n==0, or for a non-shift op, register result and flags and go to DONE.
  - DONE: res_valid=1. When res_ready=1, go to IDLE.
- Effective count n:
  - ROTR/ROTL: b[4:0] mod 20.
  - SHR/SHL: min(b[4:0], 20); a count of 20 or more yields 0.
  - All other ops: n=0.
- Arithmetic is 21-bit internally.
  - carry = bit 20 for ADD/ADDC/INC.
  - carry = borrow (1 when the unsigned result wrapped below 0) for SUB/SUBC/DEC.
  - Ops that do not update carry leave it unchanged.
- zero, sign and err are updated together with result on the EXEC→DONE edge and hold until the next op completes.

## Timing
- Reset values: state IDLE, req_ready=1, res_valid=0, result=0, zero=0, sign=0, carry=0, err=0.
- Request acceptance:
  - Request accepted on edge k (req_valid && req_ready).
  - Non-shift op: res_valid=1 after edge k+2.
  - Shift op: res_valid=1 after edge k+2+n.
- res_valid and all outputs stay stable while res_ready=0.
- Result accepted on an edge with res_valid && res_ready. req_ready rises after that edge; there is no same-cycle back-to-back acceptance.
- Inputs a, b and opcode are ignored outside the accept edge.
- rst asserted mid-EXEC or mid-DONE aborts immediately to reset values, including carry. The pending result is lost.

## Configuration
- ALU_CTRL_BARREL_EN:
  - Defined: shift/rotate results come from a barrel shifter in a single EXEC cycle. All ops have latency 2 and the count loop is not built.
  - Undefined: iterative one-bit-per-cycle shifting as described above.
  - Results and flags are identical in both builds; only latency differs.

## Test plan
- ADD a=0xFFFFF, b=0x00001, then ADDC a=0x00001, b=0x00001:
  - ADD → result=0x00000, zero=1, carry=1.
  - ADDC → result=0x00003, carry=0, both at latency 2.
- SUB a=0x00005, b=0x00007 → result=0xFFFFE, sign=1, carry=1, zero=0.
- ROTR a=0x00001, b=1 → result=0x80000, sign=1. res_valid at k+3 (iterative) or k+2 (ALU_CTRL_BARREL_EN).
- SHL a=0x00001, b=25:
  - Result=0x00000, zero=1, carry unchanged.
  - res_valid at k+22 (iterative).
  - ROTL with b=21 → result=0x00002.
- Backpressure: EQ a=b=0x12345 with res_ready=0 for 5 cycles → result=0x00001 held, res_valid=1, req_ready=0 throughout. Release → IDLE next cycle.
- Reset mid-operation and reserved opcode:
  - rst pulsed during an iterative SHR with b=15 → all outputs at reset values. A following AND a=0xF0F0F, b=0x0FF00 → result=0x00F00.
  - opcode 0x1F → result=0, err=1.
